// File: rtl/cpu_cu.sv
// cpu_cu -- multi-cycle Moore control unit for the 16-bit RISC processor.
//
// Sequences FETCH / DECODE / EXEC (or MEM / WB for loads) and drives every
// control input of the execution unit plus the memory write strobe.
// Outputs are combinational from the state register and IR_in.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   IR_in[15:0]           instruction register from the execution unit
//   N, Z, C               ALU flags, latched at the end of an ALU EXEC cycle
//   adr_sel, s_sel        address mux / ALU S-source mux selects
//   pc_load, pc_inc       PC load / increment strobes
//   pc_sel                PC source (0: PC + off, 1: ALU result)
//   ir_load, w_en         IR load / register-file write strobes
//   W_Adr, R_Adr, S_Adr   register-file addresses
//   Alu_Op[3:0]           ALU operation
//   mw_en                 memory write strobe
//   halt                  high in the HALT state
//   ill                   sticky illegal-opcode flag
//
// Configuration macro: CPU_CU_ILLEGAL_TRAP_EN
//   defined   -> illegal opcodes halt the CPU and set ill
//   undefined -> illegal opcodes run as a NOP, ill tied low
module cpu_cu (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] IR_in,
   input  logic        N,
   input  logic        Z,
   input  logic        C,
   output logic        adr_sel,
   output logic        s_sel,
   output logic        pc_load,
   output logic        pc_inc,
   output logic        pc_sel,
   output logic        ir_load,
   output logic        w_en,
   output logic [2:0]  W_Adr,
   output logic [2:0]  R_Adr,
   output logic [2:0]  S_Adr,
   output logic [3:0]  Alu_Op,
   output logic        mw_en,
   output logic        halt,
   output logic        ill
);

   localparam logic [3:0] ALU_PASS_S = 4'h0;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_LD   = 4'h2;
   localparam logic [3:0] OP_ST   = 4'h3;
   localparam logic [3:0] OP_JMP  = 4'h4;
   localparam logic [3:0] OP_JR   = 4'h5;
   localparam logic [3:0] OP_BR   = 4'h6;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t     state_q, state_d;
   logic [2:0] flg_q;          // {N, Z, C} from the last ALU instruction

   logic [3:0] op, f;
   logic [2:0] rw, rs;
   logic       illegal_op, br_taken;

   assign op = IR_in[15:12];
   assign f  = IR_in[11:8];
   assign rw = IR_in[5:3];
   assign rs = IR_in[2:0];

   // Opcodes 7..E have no defined meaning.
   assign illegal_op = (op >= 4'h7) && (op <= 4'hE);

   always_comb begin
      case (f)
         4'd0:    br_taken =  flg_q[1];
         4'd1:    br_taken = !flg_q[1];
         4'd2:    br_taken =  flg_q[2];
         4'd3:    br_taken = !flg_q[2];
         4'd4:    br_taken =  flg_q[0];
         4'd5:    br_taken = !flg_q[0];
         default: br_taken = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST:    state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            if (op == OP_LD)        state_d = S_MEM;
            else if (op == OP_HALT) state_d = S_HALT;
`ifdef CPU_CU_ILLEGAL_TRAP_EN
            else if (illegal_op)    state_d = S_HALT;
`endif
            else                    state_d = S_EXEC;
         end
         S_EXEC:   state_d = S_FETCH;
         S_MEM:    state_d = S_WB;
         S_WB:     state_d = S_FETCH;
         S_HALT:   state_d = S_HALT;
         default:  state_d = S_RST;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_RST;
         flg_q   <= 3'b000;
      end else begin
         state_q <= state_d;
         if (state_q == S_EXEC && op == OP_ALU) flg_q <= {N, Z, C};
      end
   end

`ifdef CPU_CU_ILLEGAL_TRAP_EN
   logic ill_q;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                 ill_q <= 1'b0;
      else if (state_q == S_DECODE && illegal_op) ill_q <= 1'b1;
   end
   assign ill = ill_q;
`else
   // Illegal opcodes fall through to EXEC, which drives nothing for them.
   logic unused_ill;
   assign unused_ill = illegal_op;
   assign ill = 1'b0;
`endif

   always_comb begin
      adr_sel = 1'b0;
      s_sel   = 1'b0;
      pc_load = 1'b0;
      pc_inc  = 1'b0;
      pc_sel  = 1'b0;
      ir_load = 1'b0;
      w_en    = 1'b0;
      mw_en   = 1'b0;
      W_Adr   = 3'd0;
      R_Adr   = 3'd0;
      S_Adr   = 3'd0;
      Alu_Op  = ALU_PASS_S;
      halt    = (state_q == S_HALT);
      case (state_q)
         S_FETCH: begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
         end
         S_EXEC: begin
            case (op)
               OP_ALU: begin
                  W_Adr  = rw;
                  R_Adr  = rw;
                  S_Adr  = rs;
                  Alu_Op = f;
                  w_en   = 1'b1;
               end
               OP_ST: begin
                  R_Adr   = rw;
                  adr_sel = 1'b1;
                  S_Adr   = rs;
                  mw_en   = 1'b1;
               end
               OP_JMP: pc_load = 1'b1;
               OP_JR: begin
                  S_Adr   = rs;
                  pc_sel  = 1'b1;
                  pc_load = 1'b1;
               end
               OP_BR:  pc_load = br_taken;
               default: ;
            endcase
         end
         S_MEM, S_WB: begin
            R_Adr   = rs;
            adr_sel = 1'b1;
            s_sel   = 1'b1;
            if (state_q == S_WB) begin
               W_Adr = rw;
               w_en  = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_cpu_cu.sv
// Directed bench for cpu_cu: drives IR_in and flags per instruction, checks
// the packed control outputs in every state against hand-computed values.
module tb_cpu_cu;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] IR_in = 16'h0000;
   logic        N = 1'b0, Z = 1'b0, C = 1'b0;
   logic        adr_sel, s_sel, pc_load, pc_inc, pc_sel, ir_load, w_en, mw_en, halt, ill;
   logic [2:0]  W_Adr, R_Adr, S_Adr;
   logic [3:0]  Alu_Op;

   int n_cmp = 0;
   int n_bad = 0;

   cpu_cu dut (
      .clk(clk), .reset(reset), .IR_in(IR_in), .N(N), .Z(Z), .C(C),
      .adr_sel(adr_sel), .s_sel(s_sel), .pc_load(pc_load), .pc_inc(pc_inc),
      .pc_sel(pc_sel), .ir_load(ir_load), .w_en(w_en), .W_Adr(W_Adr),
      .R_Adr(R_Adr), .S_Adr(S_Adr), .Alu_Op(Alu_Op), .mw_en(mw_en),
      .halt(halt), .ill(ill)
   );

   always #5 clk = ~clk;

   // Strobe bit positions inside the packed observation word.
   localparam logic [9:0] HLT = 10'h200, ILL = 10'h100, ADR = 10'h080, SSL = 10'h040,
                          PCL = 10'h020, PCI = 10'h010, PCS = 10'h008, IRL = 10'h004,
                          WEN = 10'h002, MWE = 10'h001;

   logic [22:0] obs;
   assign obs = {halt, ill, adr_sel, s_sel, pc_load, pc_inc, pc_sel, ir_load, w_en, mw_en,
                 W_Adr, R_Adr, S_Adr, Alu_Op};

   function automatic logic [22:0] mk(input logic [9:0] s, input logic [2:0] wa,
                                      input logic [2:0] ra, input logic [2:0] sa,
                                      input logic [3:0] op);
      return {s, wa, ra, sa, op};
   endfunction

   localparam logic [22:0] ZERO  = 23'h0;
   localparam logic [22:0] FETCH = {PCI | IRL, 13'h0};

   task automatic chk(input string tag, input logic [22:0] got, input logic [22:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Starting in FETCH: check FETCH, move to DECODE, check DECODE.
   task automatic fetch_decode(input logic [15:0] ir, input string tag);
      IR_in = ir;
      chk({tag, "_fetch"}, obs, FETCH);
      step();
      chk({tag, "_decode"}, obs, ZERO);
   endtask

   // Starting in FETCH: run a 3-cycle instruction, checking EXEC, end in FETCH.
   task automatic run3(input logic [15:0] ir, input logic [22:0] exp_exec, input string tag);
      fetch_decode(ir, tag);
      step();
      chk({tag, "_exec"}, obs, exp_exec);
      step();
   endtask

   initial begin
      // Reset held for 2 clocks; outputs must be 0 even with a live IR.
      IR_in = 16'h1A0B;
      step();
      chk("rst_0", obs, ZERO);
      step();
      chk("rst_1", obs, ZERO);
      reset = 1'b1;
      step();

      // ALU 1A0B: f=A, rw=1, rs=3; Z=1 latched.
      fetch_decode(16'h1A0B, "alu_z1");
      Z = 1'b1;
      step();
      chk("alu_z1_exec", obs, mk(WEN, 3'd1, 3'd1, 3'd3, 4'hA));
      step();
      Z = 1'b0;

      // flg.Z = 1: BNE (f=1) not taken, BEQ (f=0) taken.
      run3(16'h61FC, ZERO, "bne_z1");
      run3(16'h6000, mk(PCL, 0, 0, 0, 0), "beq_z1");

      // ALU again with Z=0 -> BNE 61FC taken.
      run3(16'h1A0B, mk(WEN, 3'd1, 3'd1, 3'd3, 4'hA), "alu_z0");
      run3(16'h61FC, mk(PCL, 0, 0, 0, 0), "bne_z0");

      // LD 2012 with Z=1 on the bus must not disturb the latched flags.
      Z = 1'b1;
      fetch_decode(16'h2012, "ld");
      step();
      chk("ld_mem", obs, mk(ADR | SSL, 3'd0, 3'd2, 3'd0, 4'h0));
      step();
      chk("ld_wb", obs, mk(ADR | SSL | WEN, 3'd2, 3'd2, 3'd0, 4'h0));
      step();
      chk("ld_back_fetch", obs, FETCH);
      run3(16'h61FC, mk(PCL, 0, 0, 0, 0), "bne_after_ld");
      Z = 1'b0;

      // ST 300A: R_Adr=rw=1, S_Adr=rs=2.
      run3(16'h300A, mk(ADR | MWE, 3'd0, 3'd1, 3'd2, 4'h0), "st");
      // JR 5005: S_Adr=5, pc_sel=1.
      run3(16'h5005, mk(PCL | PCS, 3'd0, 3'd0, 3'd5, 4'h0), "jr");
      run3(16'h40FF, mk(PCL, 0, 0, 0, 0), "jmp");
      run3(16'h0000, ZERO, "nop");
      // Unsupported branch condition never taken.
      run3(16'h6900, ZERO, "br_never");

      // Illegal opcode.
`ifdef CPU_CU_ILLEGAL_TRAP_EN
      fetch_decode(16'h7000, "illegal");
      step();
      chk("illegal_halt", obs, mk(HLT | ILL, 0, 0, 0, 0));
      step();
      chk("illegal_sticky", obs, mk(HLT | ILL, 0, 0, 0, 0));
      #1 reset = 1'b0;
      #1 chk("illegal_rst", obs, ZERO);
      step();
      reset = 1'b1;
      step();
`else
      run3(16'h7000, ZERO, "illegal_nop");
`endif
      chk("pre_halt_fetch", obs, FETCH);

      // HALT: 2 clocks to reach HALT, then absorbing.
      fetch_decode(16'hF000, "halt");
      step();
      chk("halt_0", obs, mk(HLT, 0, 0, 0, 0));
      IR_in = 16'h1A0B;
      step();
      step();
      chk("halt_2", obs, mk(HLT, 0, 0, 0, 0));
      #1 reset = 1'b0;
      #1 chk("halt_rst", obs, ZERO);
      step();
      reset = 1'b1;
      step();
      chk("post_halt_fetch", obs, FETCH);

      // Reset asynchronously mid-EXEC: strobes drop at once.
      fetch_decode(16'h1A0B, "abort");
      step();
      chk("abort_exec", obs, mk(WEN, 3'd1, 3'd1, 3'd3, 4'hA));
      #1 reset = 1'b0;
      #1 chk("abort_rst", obs, ZERO);
      step();
      chk("abort_hold", obs, ZERO);
      reset = 1'b1;
      step();
      chk("abort_refetch", obs, FETCH);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
